// File: rtl/divide.sv
// divide: sequential 8-bit / 4-bit unsigned restoring divider, one quotient bit per clock.
// Ports: DIV_CLK clock; RST sync active-high reset; DIN0..DIN3 nibble write bus; LOAD/SEL1:SEL0
//   select the operand to write or the nibble to read; START begins a division; BUSY/DONE/DIVZ status;
//   R0..R3 combinational read nibble (quot lo | quot hi | rem | {0,DIVZ,DONE,BUSY}).
module divide #(
  parameter logic [7:0] DIVZ_QUOT = 8'hFF,
  parameter logic [3:0] DIVZ_REM  = 4'h0
) (
  input  logic DIV_CLK,
  input  logic RST,
  input  logic DIN0,
  input  logic DIN1,
  input  logic DIN2,
  input  logic DIN3,
  input  logic LOAD,
  input  logic SEL0,
  input  logic SEL1,
  input  logic START,
  output logic BUSY,
  output logic DONE,
  output logic DIVZ,
  output logic R0,
  output logic R1,
  output logic R2,
  output logic R3
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [3:0] divisor;
  logic [7:0] dividend;
  // Partial remainder. Its top bit is always zero between iterations (remainder < divisor),
  // so only the low nibble is held; the 5-bit width lives in the trial subtraction.
  logic [3:0] p;
  logic [7:0] q;       // dividend shifts out the top, quotient bits shift in at the bottom
  logic [2:0] cnt;
  logic       divz;

  logic [3:0] din;
  logic [1:0] sel;
  logic [4:0] trial;
  logic       qbit;
  logic       do_load;
  logic       do_start;
  logic       do_divz;
  logic [3:0] rd;

  assign din = {DIN3, DIN2, DIN1, DIN0};
  assign sel = {SEL1, SEL0};

  // Shifted remainder is at most 2*divisor-1, so the difference lies in -15..14 and
  // bit 4 of the 5-bit result is a reliable sign bit.
  assign trial = {p, q[7]} - {1'b0, divisor};
  assign qbit  = ~trial[4];

  always_ff @(posedge DIV_CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    do_load   = 1'b0;
    do_start  = 1'b0;
    do_divz   = 1'b0;
    case (state)
      ST_RUN: begin
        if (cnt == 3'd7) begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        // LOAD has priority over START; a LOAD from DONE retires the result.
        if (LOAD) begin
          do_load   = 1'b1;
          state_nxt = ST_IDLE;
        end else if (START) begin
          if (divisor == 4'd0) begin
            do_divz   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            do_start  = 1'b1;
            state_nxt = ST_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge DIV_CLK) begin
    if (RST) begin
      divisor  <= 4'd0;
      dividend <= 8'd0;
      p        <= 4'd0;
      q        <= 8'd0;
      cnt      <= 3'd0;
      divz     <= 1'b0;
    end else begin
      if (do_load) begin
        divz <= 1'b0;
        case (sel)
          2'd0:    divisor       <= din;
          2'd1:    dividend[3:0] <= din;
          2'd2:    dividend[7:4] <= din;
          default: ;
        endcase
      end
      if (do_start) begin
        p    <= 4'd0;
        q    <= dividend;
        cnt  <= 3'd0;
        divz <= 1'b0;
      end
      if (do_divz) begin
        p    <= DIVZ_REM;
        q    <= DIVZ_QUOT;
        divz <= 1'b1;
      end
      if (state == ST_RUN) begin
        p   <= qbit ? trial[3:0] : {p[2:0], q[7]};
        q   <= {q[6:0], qbit};
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign BUSY = (state == ST_RUN);
  assign DONE = (state == ST_DONE);
  assign DIVZ = divz;

  always_comb begin
    rd = 4'd0;
    case (sel)
      2'd0:    rd = q[3:0];
      2'd1:    rd = q[7:4];
      2'd2:    rd = p;
      default: rd = {1'b0, DIVZ, DONE, BUSY};
    endcase
  end

  assign {R3, R2, R1, R0} = rd;

endmodule

// File: tb/tb_divide.sv
// tb_divide: directed and exhaustive checks of the divide block against an arithmetic model.
module tb_divide;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'd0;
  logic [1:0] sel = 2'd0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, divz;
  logic       r0, r1, r2, r3;
  logic [3:0] rd;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  assign rd = {r3, r2, r1, r0};

  always #10 clk = ~clk;

  divide dut (
    .DIV_CLK(clk), .RST(rst),
    .DIN0(din[0]), .DIN1(din[1]), .DIN2(din[2]), .DIN3(din[3]),
    .LOAD(load), .SEL0(sel[0]), .SEL1(sel[1]), .START(start),
    .BUSY(busy), .DONE(done), .DIVZ(divz),
    .R0(r0), .R1(r1), .R2(r2), .R3(r3)
  );

  // Behavioural model: results come straight from / and %, timing from the cycle count.
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  int       m_state = M_IDLE;
  int       m_cnt = 0;
  int       m_dvs = 0;
  int       m_dvd = 0;
  int       m_quot = 0;
  int       m_rem = 0;
  bit       m_divz = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_state <= M_IDLE; m_cnt <= 0; m_dvs <= 0; m_dvd <= 0;
      m_quot <= 0; m_rem <= 0; m_divz <= 1'b0;
    end else if (m_state == M_RUN) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 7) m_state <= M_DONE;
    end else if (load) begin
      if (sel == 2'd0) m_dvs <= din;
      if (sel == 2'd1) m_dvd <= (m_dvd & 8'hF0) | din;
      if (sel == 2'd2) m_dvd <= (m_dvd & 8'h0F) | (din << 4);
      m_state <= M_IDLE;
      m_divz  <= 1'b0;
    end else if (start) begin
      if (m_dvs == 0) begin
        m_state <= M_DONE; m_quot <= 8'hFF; m_rem <= 0; m_divz <= 1'b1;
      end else begin
        m_state <= M_RUN; m_cnt <= 0; m_divz <= 1'b0;
        m_quot <= m_dvd / m_dvs; m_rem <= m_dvd % m_dvs;
      end
    end
  end

  function automatic logic [3:0] exp_read(input logic [1:0] s);
    logic [7:0] qv;
    qv = m_quot[7:0];
    case (s)
      2'd0:    return qv[3:0];
      2'd1:    return qv[7:4];
      2'd2:    return m_rem[3:0];
      default: return {1'b0, m_divz, m_state == M_DONE, m_state == M_RUN};
    endcase
  endfunction

  // Per-cycle compare: status always, read nibble whenever it is architecturally defined.
  always @(negedge clk) begin
    if (chk_en) begin
      n_vec++;
      if ({busy, done, divz} !== {m_state == M_RUN, m_state == M_DONE, m_divz}) begin
        n_err++;
        $display("FAIL flags @%0t: got busy/done/divz=%b%b%b expected %b%b%b", $time,
                 busy, done, divz, m_state == M_RUN, m_state == M_DONE, m_divz);
      end
      if (sel == 2'd3 || m_state != M_RUN) begin
        n_vec++;
        if (rd !== exp_read(sel)) begin
          n_err++;
          $display("FAIL read sel=%0d @%0t: got %h expected %h", sel, $time, rd, exp_read(sel));
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load_op(input logic [1:0] s, input logic [3:0] v);
    sel = s; din = v; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic rd_nib(input logic [1:0] s, output logic [3:0] v);
    sel = s;
    #1;
    v = rd;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic read_result(output int q, output int r);
    logic [3:0] lo, hi, rm;
    rd_nib(2'd0, lo);
    rd_nib(2'd1, hi);
    rd_nib(2'd2, rm);
    q = {hi, lo};
    r = rm;
  endtask

  task automatic div_once(input logic [3:0] dvs, input logic [7:0] dvd,
                          output int q, output int r, output int k);
    load_op(2'd0, dvs);
    load_op(2'd1, dvd[3:0]);
    load_op(2'd2, dvd[7:4]);
    go();
    wait_done(k);
    read_result(q, r);
  endtask

  initial begin
    int q, r, k;
    logic [3:0] v;

    // Reset
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;
    rd_nib(2'd3, v); chk("reset_status", v, 4'b0000);
    read_result(q, r);
    chk("reset_quot", q, 0);
    chk("reset_rem", r, 0);

    // 200 / 7
    div_once(4'd7, 8'hC8, q, r, k);
    chk("200/7_latency", k, 8);
    chk("200/7_quot", q, 8'h1C);
    chk("200/7_rem", r, 4);
    rd_nib(2'd3, v); chk("200/7_status", v, 4'b0010);

    // 255 / 1 and 5 / 9
    div_once(4'd1, 8'hFF, q, r, k);
    chk("255/1_quot", q, 8'hFF);
    chk("255/1_rem", r, 0);
    div_once(4'd9, 8'h05, q, r, k);
    chk("5/9_quot", q, 8'h00);
    chk("5/9_rem", r, 5);

    // Divide by zero: DONE on the very next edge, BUSY never seen
    div_once(4'd0, 8'h3A, q, r, k);
    chk("divz_latency", k, 0);
    chk("divz_quot", q, 8'hFF);
    chk("divz_rem", r, 0);
    rd_nib(2'd3, v); chk("divz_status", v, 4'b0110);

    // LOAD (even to the status slot) from DONE clears flags, keeps result
    load_op(2'd3, 4'd5);
    rd_nib(2'd3, v); chk("load_from_done_status", v, 4'b0000);
    rd_nib(2'd1, v); chk("load_from_done_quot_hi", v, 4'hF);

    // START together with LOAD in DONE: the load wins
    div_once(4'd7, 8'hC8, q, r, k);
    sel = 2'd0; din = 4'd0; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    rd_nib(2'd3, v); chk("start_load_status", v, 4'b0000);
    go();
    chk("start_load_divz", divz, 1);

    // START and LOAD during RUN are ignored
    load_op(2'd0, 4'd7);
    go();
    tick(); tick();
    sel = 2'd0; din = 4'd3; load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    wait_done(k);
    read_result(q, r);
    chk("run_ignore_quot", q, 8'h1C);
    chk("run_ignore_rem", r, 4);
    go();
    wait_done(k);
    read_result(q, r);
    chk("run_ignore_latency", k, 8);
    chk("divisor_unchanged_quot", q, 8'h1C);

    // Reset mid-run aborts
    go();
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd_nib(2'd3, v); chk("abort_status", v, 4'b0000);
    read_result(q, r);
    chk("abort_quot", q, 0);
    chk("abort_rem", r, 0);
    div_once(4'hA, 8'h64, q, r, k);
    chk("100/10_quot", q, 8'h0A);
    chk("100/10_rem", r, 0);

    // Exhaustive nonzero-divisor sweep
    for (int d = 1; d < 16; d++) begin
      for (int x = 0; x < 256; x++) begin
        div_once(d[3:0], x[7:0], q, r, k);
        chk($sformatf("sweep_%0d/%0d_inv", x, d), (q * d + r == x) && (r < d), 1);
        chk($sformatf("sweep_%0d/%0d_lat", x, d), k, 8);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
